// File: rtl/beta_decode_issue_if.sv
// Handshake bundle between the decode/issue stage, its instruction source,
// the ALU side and the writeback port.
//
// Handshake rule (both directions): a transfer happens on the rising clock
// edge where valid and ready are both 1. A producer holding valid=1 keeps its
// payload stable until that edge. Ready may depend combinationally on valid.
interface beta_decode_issue_if #(
  parameter int DWIDTH = 32
);
  logic              in_valid;
  logic [31:0]       in_instr;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [5:0]        out_opcode;
  logic [DWIDTH-1:0] out_ra;
  logic [DWIDTH-1:0] out_rb;
  logic [4:0]        out_rc_addr;
  logic              wb_en;
  logic [4:0]        wb_addr;
  logic [DWIDTH-1:0] wb_data;
  logic              illegal_op;

  // Environment side: instruction source, ALU consumer and writeback driver
  modport master (
    output in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data,
    input  in_ready, out_valid, out_opcode, out_ra, out_rb, out_rc_addr,
           illegal_op
  );

  // Decode/issue stage side
  modport slave (
    input  in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data,
    output in_ready, out_valid, out_opcode, out_ra, out_rb, out_rc_addr,
           illegal_op
  );
endinterface

// File: rtl/beta_decode_issue.sv
// Beta operand-fetch/issue stage: decodes the instruction, reads Ra/Rb from
// the local register file (with same-cycle writeback bypass), substitutes the
// sign-extended literal for constant-format ops, and stalls on RAW/WAW
// hazards tracked by a one-writer-per-register pending scoreboard.
module beta_decode_issue #(
  parameter int DWIDTH = 32,
  parameter int NREGS  = 32
) (
  input logic            clk,
  input logic            rst_n,
  beta_decode_issue_if.slave bus
);
  localparam logic [4:0] ZREG = 5'(NREGS - 1);

  logic [DWIDTH-1:0] rf [NREGS];
  logic [NREGS-1:0]  pending;

  logic [5:0]  opcode;
  logic [4:0]  rc, ra, rb;
  logic [15:0] lit;
  logic        alu_class, opc_fmt;
  logic [DWIDTH-1:0] ra_val, rb_val;
  logic        hazard, accept;

  assign opcode    = bus.in_instr[31:26];
  assign rc        = bus.in_instr[25:21];
  assign ra        = bus.in_instr[20:16];
  assign rb        = bus.in_instr[15:11];
  assign lit       = bus.in_instr[15:0];
  assign alu_class = opcode[5];
  assign opc_fmt   = opcode[4];

  // True when the writeback port is updating register idx this cycle
  function automatic logic wb_hit(input logic [4:0] idx);
    return bus.wb_en && (bus.wb_addr == idx) && (idx != ZREG);
  endfunction

  // Pending bit as seen after a same-cycle writeback has retired it
  function automatic logic eff_pend(input logic [4:0] idx);
    return pending[idx] & ~wb_hit(idx);
  endfunction

  // Ra operand: R31 is zero, otherwise bypass writeback data over stored value
  always_comb begin
    ra_val = rf[ra];
    if (wb_hit(ra)) ra_val = bus.wb_data;
    if (ra == ZREG) ra_val = '0;
  end

  // Rb operand: sign-extended literal for OPC, else register read with bypass
  always_comb begin
    rb_val = rf[rb];
    if (wb_hit(rb)) rb_val = bus.wb_data;
    if (rb == ZREG) rb_val = '0;
    if (opc_fmt)    rb_val = {{(DWIDTH-16){lit[15]}}, lit};
  end

  // Hazard check and input handshake; illegal ops never stall on the scoreboard
  always_comb begin
    hazard = eff_pend(ra) | (~opc_fmt & eff_pend(rb)) | eff_pend(rc);
    bus.in_ready = (~bus.out_valid | bus.out_ready)
                   & ~(bus.in_valid & alu_class & hazard);
    accept = bus.in_valid & bus.in_ready;
  end

  // Register file: writeback port only, R31 never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (bus.wb_en && bus.wb_addr != ZREG) begin
      rf[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Scoreboard: writeback clears, issue sets; the later assignment makes set win
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      if (bus.wb_en && bus.wb_addr != ZREG) pending[bus.wb_addr] <= 1'b0;
      if (accept && alu_class && rc != ZREG) pending[rc] <= 1'b1;
    end
  end

  // Output register stage: load on ALU-class accept, drop valid once consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid   <= 1'b0;
      bus.out_opcode  <= '0;
      bus.out_ra      <= '0;
      bus.out_rb      <= '0;
      bus.out_rc_addr <= '0;
    end else if (accept && alu_class) begin
      bus.out_valid   <= 1'b1;
      bus.out_opcode  <= opcode;
      bus.out_ra      <= ra_val;
      bus.out_rb      <= rb_val;
      bus.out_rc_addr <= rc;
    end else if (bus.out_ready) begin
      bus.out_valid   <= 1'b0;
    end
  end

  // One-cycle pulse when a non-ALU instruction is consumed and dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.illegal_op <= 1'b0;
    else        bus.illegal_op <= accept & ~alu_class;
  end
endmodule

// File: tb/tb_beta_decode_issue.sv
// Directed bench for beta_decode_issue: stimulus pushes hand-computed issued
// ops into exp_q, a negedge monitor pops/compares every consumed output and
// checks that held outputs stay stable under backpressure.
module tb_beta_decode_issue;
  logic clk;
  logic rst_n;
  beta_decode_issue_if #(.DWIDTH(32)) bus ();

  beta_decode_issue #(.DWIDTH(32), .NREGS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [74:0] exp_q[$];
  logic [74:0] out_vec;
  logic [74:0] held_vec;
  logic        held;

  assign out_vec = {bus.out_opcode, bus.out_ra, bus.out_rb, bus.out_rc_addr};

  // Clock / reset-independent clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [74:0] act, input logic [74:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [74:0] ev(input logic [5:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input logic [4:0] c);
    return {op, a, b, c};
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] c,
                                     input logic [4:0] a, input logic [4:0] b);
    return {op, c, a, b, 11'b0};
  endfunction

  function automatic logic [31:0] mkc(input logic [5:0] op, input logic [4:0] c,
                                      input logic [4:0] a, input logic [15:0] l);
    return {op, c, a, l};
  endfunction

  // Monitor: compare consumed outputs against the queue, check hold stability
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) chk("hold_stable", out_vec, held_vec);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", out_vec, '0 ^ {75{1'b1}} ^ out_vec ^ out_vec);
        else chk("issued_op", out_vec, exp_q.pop_front());
      end
      held     = bus.out_valid && !bus.out_ready;
      held_vec = out_vec;
    end
  end

  // Driver: one writeback on the next edge
  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    bus.wb_en = 1'b1; bus.wb_addr = a; bus.wb_data = d;
    @(posedge clk); #1;
    bus.wb_en = 1'b0;
  endtask

  // Driver: present an instruction, wait (bounded) for acceptance
  task automatic issue(input logic [31:0] instr, output int stalls);
    bus.in_valid = 1'b1; bus.in_instr = instr; stalls = 0;
    #1;
    while (!bus.in_ready && stalls < 40) begin
      @(posedge clk); #2;
      stalls++;
    end
    if (!bus.in_ready) chk("issue_timeout", 75'(bus.in_ready), 75'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  int st;

  initial begin
    rst_n = 1'b0; held = 1'b0; held_vec = '0;
    bus.in_valid = 0; bus.in_instr = 0; bus.out_ready = 1;
    bus.wb_en = 0; bus.wb_addr = 0; bus.wb_data = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 75'(bus.out_valid), 75'(0));
    chk("rst_out_vec", out_vec, '0);
    chk("rst_illegal", 75'(bus.illegal_op), 75'(0));
    chk("rst_in_ready", 75'(bus.in_ready), 75'(1));
    @(posedge clk); #1;

    // Basic OP issue
    wb(5'd1, 32'd5);
    wb(5'd2, 32'd7);
    exp_q.push_back(ev(6'h20, 32'd5, 32'd7, 5'd3));
    issue(mk(6'h20, 5'd3, 5'd1, 5'd2), st);

    // OPC literal sign extension, back-to-back
    exp_q.push_back(ev(6'h30, 32'd5, 32'hFFFFFFFE, 5'd4));
    issue(mkc(6'h30, 5'd4, 5'd1, 16'hFFFE), st);
    chk("opc_no_stall", 75'(st), 75'(0));
    exp_q.push_back(ev(6'h30, 32'd7, 32'h00007FFF, 5'd6));
    issue(mkc(6'h30, 5'd6, 5'd2, 16'h7FFF), st);

    // RAW on R3: stalls until writeback, which is bypassed on the accept edge
    bus.in_valid = 1'b1; bus.in_instr = mk(6'h20, 5'd5, 5'd3, 5'd1);
    for (int i = 0; i < 3; i++) begin
      #1 chk("raw_stall", 75'(bus.in_ready), 75'(0));
      @(posedge clk); #1;
    end
    bus.wb_en = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'd9;
    exp_q.push_back(ev(6'h20, 32'd9, 32'd5, 5'd5));
    #1 chk("raw_release", 75'(bus.in_ready), 75'(1));
    @(posedge clk); #1;
    bus.wb_en = 1'b0;
    bus.in_instr = mk(6'h20, 5'd7, 5'd5, 5'd1);
    #1 chk("pending5_set", 75'(bus.in_ready), 75'(0));
    bus.in_instr = mk(6'h20, 5'd7, 5'd3, 5'd1);
    exp_q.push_back(ev(6'h20, 32'd9, 32'd5, 5'd7));
    #1 chk("pending3_clear", 75'(bus.in_ready), 75'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wb(5'd5, 32'd11); wb(5'd4, 32'd0); wb(5'd6, 32'd0); wb(5'd7, 32'd0);

    // R31: zero reads, never pending, writes ignored
    exp_q.push_back(ev(6'h20, 32'd0, 32'd0, 5'd31));
    issue(mk(6'h20, 5'd31, 5'd31, 5'd31), st);
    exp_q.push_back(ev(6'h20, 32'd0, 32'd0, 5'd31));
    issue(mk(6'h20, 5'd31, 5'd31, 5'd31), st);
    chk("r31_no_stall", 75'(st), 75'(0));
    wb(5'd31, 32'h55);
    exp_q.push_back(ev(6'h21, 32'd0, 32'd0, 5'd8));
    issue(mk(6'h21, 5'd8, 5'd31, 5'd31), st);
    chk("r31_wb_ignored_no_stall", 75'(st), 75'(0));

    // Same-cycle writeback and read of a non-pending register
    bus.wb_en = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'h1234;
    exp_q.push_back(ev(6'h22, 32'h1234, 32'd0, 5'd14));
    issue(mk(6'h22, 5'd14, 5'd9, 5'd31), st);
    bus.wb_en = 1'b0;
    chk("bypass_no_stall", 75'(st), 75'(0));
    wb(5'd8, 32'd0); wb(5'd14, 32'd0);

    // Backpressure: A held on the output, B waits, then both flow in order
    bus.out_ready = 1'b0;
    exp_q.push_back(ev(6'h20, 32'd5, 32'd7, 5'd10));
    issue(mk(6'h20, 5'd10, 5'd1, 5'd2), st);
    exp_q.push_back(ev(6'h23, 32'd7, 32'd5, 5'd11));
    bus.in_valid = 1'b1; bus.in_instr = mk(6'h23, 5'd11, 5'd2, 5'd1);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_in_ready", 75'(bus.in_ready), 75'(0));
      chk("bp_out_valid", 75'(bus.out_valid), 75'(1));
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    #1 chk("bp_release", 75'(bus.in_ready), 75'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_drained", 75'(bus.out_valid), 75'(0));

    // Illegal opcode: consumed, one-cycle pulse, no output
    bus.in_valid = 1'b1; bus.in_instr = mk(6'h1B, 5'd12, 5'd1, 5'd2);
    #1 chk("ill_ready", 75'(bus.in_ready), 75'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("ill_pulse", 75'(bus.illegal_op), 75'(1));
    chk("ill_no_valid", 75'(bus.out_valid), 75'(0));
    @(posedge clk); #1;
    chk("ill_pulse_end", 75'(bus.illegal_op), 75'(0));
    // The dropped op must not have marked R12 pending
    exp_q.push_back(ev(6'h20, 32'd0, 32'd0, 5'd13));
    issue(mk(6'h20, 5'd13, 5'd12, 5'd31), st);
    chk("ill_no_pending", 75'(st), 75'(0));
    wb(5'd13, 32'd0);

    // Asynchronous reset during a stall
    bus.out_ready = 1'b0;
    exp_q.push_back(ev(6'h20, 32'd5, 32'd7, 5'd12));
    issue(mk(6'h20, 5'd12, 5'd1, 5'd2), st);
    bus.in_valid = 1'b1; bus.in_instr = mk(6'h20, 5'd15, 5'd12, 5'd1);
    #1 chk("pre_rst_stall", 75'(bus.in_ready), 75'(0));
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_out_valid", 75'(bus.out_valid), 75'(0));
    chk("arst_out_vec", out_vec, '0);
    chk("arst_pending_clear", 75'(bus.in_ready), 75'(1));
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(ev(6'h20, 32'd0, 32'd0, 5'd13));
    issue(mk(6'h20, 5'd13, 5'd1, 5'd2), st);
    chk("post_rst_no_stall", 75'(st), 75'(0));

    // Drain with a bound
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1 chk("queue_empty", 75'(exp_q.size()), 75'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
